// File: rtl/mioc_dma_pkg.sv
// Shared widths, timeout default and state encodings for the MIOC DMA initiator.
package mioc_dma_pkg;

  localparam int unsigned ADDR_W_DEF        = 16;
  localparam int unsigned DATA_W_DEF        = 8;
  localparam int unsigned LEN_W_DEF         = 8;
  localparam int unsigned GRANT_TIMEOUT_DEF = 255;

  // Top-level handshake; ST_XFER covers the whole ADDR/STRB/NEXT byte loop.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_REL,
    ST_ERR
  } dma_state_t;

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_ADDR,
    CYC_STRB,
    CYC_NEXT
  } cyc_state_t;

  function automatic logic cyc_on_bus(input cyc_state_t s);
    return s != CYC_IDLE;
  endfunction

endpackage

// File: rtl/mioc_dma_memcyc.sv
// Single-byte memory cycle sequencer (ADDR -> STRB -> NEXT) with registered bus strobes.
module mioc_dma_memcyc
  import mioc_dma_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              launch,
  input  logic              kill,
  input  logic              dir,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              wait_n,
  input  logic [DATA_W-1:0] bd_in,
  output cyc_state_t        phase,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] bd_out,
  output logic              bd_oe,
  output logic              bmreq_n,
  output logic              brd_n,
  output logic              bwr_n
);

  cyc_state_t phase_nxt;

  always_comb begin
    phase_nxt = phase;
    if (kill) begin
      phase_nxt = CYC_IDLE;
    end else begin
      case (phase)
        CYC_IDLE: if (launch) phase_nxt = CYC_ADDR;
        CYC_ADDR: if (!dir || wr_valid) phase_nxt = CYC_STRB;
        CYC_STRB: if (wait_n) phase_nxt = CYC_NEXT;
        CYC_NEXT: phase_nxt = launch ? CYC_ADDR : CYC_IDLE;
        default:  phase_nxt = CYC_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next phase so they change on the same edge as the phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= CYC_IDLE;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      bd_out   <= '0;
      bd_oe    <= 1'b0;
      bmreq_n  <= 1'b1;
      brd_n    <= 1'b1;
      bwr_n    <= 1'b1;
    end else begin
      phase    <= phase_nxt;
      wr_ready <= (phase_nxt == CYC_ADDR) && dir;
      rd_valid <= (phase_nxt == CYC_NEXT) && !dir;
      bd_oe    <= cyc_on_bus(phase_nxt);
      bmreq_n  <= !((phase_nxt == CYC_ADDR) || (phase_nxt == CYC_STRB));
      bwr_n    <= !((phase_nxt == CYC_STRB) && dir);
      brd_n    <= !((phase_nxt == CYC_STRB) && !dir);
      if (!kill && (phase == CYC_ADDR) && dir && wr_valid) bd_out <= wr_data;
      if (!kill && (phase == CYC_STRB) && !dir && wait_n) rd_data <= bd_in;
    end
  end

endmodule

// File: rtl/mioc_dma_initiator.sv
// DMA master toward MIOC: requests the bus, runs a byte burst, then releases or aborts.
module mioc_dma_initiator
  import mioc_dma_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned LEN_W         = LEN_W_DEF,
  parameter int unsigned GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  logic              B_PHI,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              DIR_WR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic              DMA_N,
  input  logic              ADDRBUFEN_N,
  output logic              OS3_N,
  input  logic              IS3_N,
  input  logic              WAIT_N,
  output logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] BD_OUT,
  input  logic [DATA_W-1:0] BD_IN,
  output logic              BD_OE,
  output logic              BMREQ_N,
  output logic              BRD_N,
  output logic              BWR_N
);

  localparam int unsigned TCNT_W = $clog2(GRANT_TIMEOUT + 1);

  dma_state_t        state, state_nxt;
  cyc_state_t        phase;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [TCNT_W-1:0] tcnt;
  logic              dir;
  logic              abort, launch, timeout_hit, last_byte;

  assign BA = addr;

  always_comb begin
    abort       = !IS3_N && ((state == ST_REQ) || (state == ST_XFER));
    // Compared before the increment, so REQ lasts exactly GRANT_TIMEOUT cycles.
    timeout_hit = (tcnt == TCNT_W'(GRANT_TIMEOUT - 1));
    last_byte   = (phase == CYC_NEXT) && (cnt == '0);
    launch      = !abort && (((state == ST_REQ) && !ADDRBUFEN_N) ||
                             ((state == ST_XFER) && (phase == CYC_NEXT) && (cnt != '0)));
    state_nxt   = state;
    case (state)
      ST_IDLE: if (START) state_nxt = ST_REQ;
      ST_REQ: begin
        if (abort)             state_nxt = ST_ERR;
        else if (!ADDRBUFEN_N) state_nxt = ST_XFER;
        else if (timeout_hit)  state_nxt = ST_ERR;
      end
      ST_XFER: begin
        if (abort)          state_nxt = ST_ERR;
        else if (last_byte) state_nxt = ST_REL;
      end
      ST_REL:  state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge B_PHI) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      addr  <= '0;
      cnt   <= '0;
      tcnt  <= '0;
      dir   <= 1'b0;
      DMA_N <= 1'b1;
      OS3_N <= 1'b1;
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      DMA_N <= !((state_nxt == ST_REQ) || (state_nxt == ST_XFER));
      OS3_N <= state_nxt != ST_REL;
      DONE  <= (state_nxt == ST_REL) || (state_nxt == ST_ERR);
      ERROR <= state_nxt == ST_ERR;
      BUSY  <= state_nxt != ST_IDLE;
      case (state)
        ST_IDLE: if (START) begin
          addr <= START_ADDR;
          cnt  <= LEN;
          dir  <= DIR_WR;
          tcnt <= '0;
        end
        ST_REQ: tcnt <= tcnt + TCNT_W'(1);
        ST_XFER: if (!abort && (phase == CYC_NEXT)) begin
          addr <= addr + ADDR_W'(1);
          if (cnt != '0) cnt <= cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  mioc_dma_memcyc #(.DATA_W(DATA_W)) u_memcyc (
    .clk      (B_PHI),
    .rst_n    (RST_N),
    .launch   (launch),
    .kill     (abort),
    .dir      (dir),
    .wr_data  (WR_DATA),
    .wr_valid (WR_VALID),
    .wait_n   (WAIT_N),
    .bd_in    (BD_IN),
    .phase    (phase),
    .wr_ready (WR_READY),
    .rd_data  (RD_DATA),
    .rd_valid (RD_VALID),
    .bd_out   (BD_OUT),
    .bd_oe    (BD_OE),
    .bmreq_n  (BMREQ_N),
    .brd_n    (BRD_N),
    .bwr_n    (BWR_N)
  );

endmodule

// File: tb/tb_mioc_dma_initiator.sv
// Directed bench for mioc_dma_initiator: one task per scenario, inline expected values.
module tb_mioc_dma_initiator;

  logic        B_PHI = 1'b0;
  logic        RST_N, START, DIR_WR, WR_VALID, ADDRBUFEN_N, IS3_N, WAIT_N;
  logic [15:0] START_ADDR;
  logic [7:0]  LEN, WR_DATA, BD_IN;
  logic        WR_READY, RD_VALID, BUSY, DONE, ERROR, DMA_N, OS3_N;
  logic        BD_OE, BMREQ_N, BRD_N, BWR_N;
  logic [7:0]  RD_DATA, BD_OUT;
  logic [15:0] BA;

  int checks = 0;
  int failures = 0;

  always #5 B_PHI = ~B_PHI;

  mioc_dma_initiator #(
    .ADDR_W(16), .DATA_W(8), .LEN_W(8), .GRANT_TIMEOUT(255)
  ) dut (
    .B_PHI(B_PHI), .RST_N(RST_N), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
    .DIR_WR(DIR_WR), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .DMA_N(DMA_N), .ADDRBUFEN_N(ADDRBUFEN_N), .OS3_N(OS3_N), .IS3_N(IS3_N),
    .WAIT_N(WAIT_N), .BA(BA), .BD_OUT(BD_OUT), .BD_IN(BD_IN), .BD_OE(BD_OE),
    .BMREQ_N(BMREQ_N), .BRD_N(BRD_N), .BWR_N(BWR_N)
  );

  task automatic tick;
    @(posedge B_PHI);
    #1;
  endtask

  // Leaves the bench in the first REQ cycle.
  task automatic start_burst(input logic [15:0] a, input logic [7:0] l, input logic d);
    START_ADDR = a; LEN = l; DIR_WR = d; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick(); tick();
    checks++; if ({DMA_N, OS3_N, BMREQ_N, BRD_N, BWR_N} !== 5'b11111) begin
      failures++; $display("FAIL reset_high_outs got=%b exp=11111", {DMA_N, OS3_N, BMREQ_N, BRD_N, BWR_N}); end
    checks++; if ({BUSY, DONE, ERROR, BD_OE, WR_READY, RD_VALID} !== 6'b0) begin
      failures++; $display("FAIL reset_low_outs got=%b exp=000000", {BUSY, DONE, ERROR, BD_OE, WR_READY, RD_VALID}); end
    checks++; if ({BA, BD_OUT, RD_DATA} !== 32'h0) begin
      failures++; $display("FAIL reset_buses got=%h exp=00000000", {BA, BD_OUT, RD_DATA}); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_min_latency;
    ADDRBUFEN_N = 1'b0; WR_VALID = 1'b1; WR_DATA = 8'h3C;
    start_burst(16'h1234, 8'd0, 1'b1);
    checks++; if ({BUSY, DMA_N, BMREQ_N, BD_OE} !== 4'b1010) begin
      failures++; $display("FAIL lat_req got=%b exp=1010", {BUSY, DMA_N, BMREQ_N, BD_OE}); end
    tick();
    checks++; if ({BMREQ_N, BD_OE, WR_READY, BWR_N, BA} !== {4'b0111, 16'h1234}) begin
      failures++; $display("FAIL lat_addr got=%h exp=%h", {BMREQ_N, BD_OE, WR_READY, BWR_N, BA}, {4'b0111, 16'h1234}); end
    tick();
    checks++; if ({BMREQ_N, BWR_N, BRD_N, BD_OUT} !== {3'b001, 8'h3C}) begin
      failures++; $display("FAIL lat_strb got=%h exp=%h", {BMREQ_N, BWR_N, BRD_N, BD_OUT}, {3'b001, 8'h3C}); end
    tick();
    checks++; if ({BMREQ_N, BWR_N, BD_OE, DONE} !== 4'b1110) begin
      failures++; $display("FAIL lat_next got=%b exp=1110", {BMREQ_N, BWR_N, BD_OE, DONE}); end
    tick();
    checks++; if ({DMA_N, BD_OE, OS3_N, DONE, ERROR, BUSY} !== 6'b100101) begin
      failures++; $display("FAIL lat_rel got=%b exp=100101", {DMA_N, BD_OE, OS3_N, DONE, ERROR, BUSY}); end
    tick();
    checks++; if ({BUSY, DONE, OS3_N, BA} !== {3'b001, 16'h1235}) begin
      failures++; $display("FAIL lat_idle got=%h exp=%h", {BUSY, DONE, OS3_N, BA}, {3'b001, 16'h1235}); end
    ADDRBUFEN_N = 1'b1; WR_VALID = 1'b0;
  endtask

  task automatic test_write_burst;
    int npulse = 0, os3 = 0, dn = 0, er = 0, busyc = 0, wi = 0;
    logic pend = 1'b0, fin = 1'b0;
    logic [15:0] pba [4];
    logic [7:0]  pbd [4];
    WR_VALID = 1'b1; WR_DATA = 8'hC0;
    start_burst(16'h4000, 8'd3, 1'b1);
    for (int k = 0; k < 40 && !fin; k++) begin
      if (BUSY) busyc++;
      if (!BWR_N) begin
        if (npulse < 4) begin pba[npulse] = BA; pbd[npulse] = BD_OUT; end
        npulse++;
      end
      if (!OS3_N) os3++;
      if (DONE) dn++;
      if (ERROR) er++;
      if (!BUSY) fin = 1'b1;
      else begin
        if (k == 1) ADDRBUFEN_N = 1'b0;
        if (WR_READY) pend = 1'b1;
        tick();
        if (pend) begin wi++; WR_DATA = 8'(8'hC0 + wi); pend = 1'b0; end
      end
    end
    checks++; if (fin !== 1'b1) begin failures++; $display("FAIL wr_burst_end got=%b exp=1", fin); end
    checks++; if (npulse != 4) begin failures++; $display("FAIL wr_pulses got=%0d exp=4", npulse); end
    if (npulse >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if ({pba[i], pbd[i]} !== {16'(16'h4000 + i), 8'(8'hC0 + i)}) begin
          failures++; $display("FAIL wr_byte%0d got=%h exp=%h", i, {pba[i], pbd[i]}, {16'(16'h4000 + i), 8'(8'hC0 + i)}); end
      end
    end
    checks++; if ({os3, dn, er} != {32'd1, 32'd1, 32'd0}) begin
      failures++; $display("FAIL wr_os3_done_err got=%0d/%0d/%0d exp=1/1/0", os3, dn, er); end
    checks++; if (busyc != 15) begin failures++; $display("FAIL wr_busy_cycles got=%0d exp=15", busyc); end
    ADDRBUFEN_N = 1'b1; WR_VALID = 1'b0;
  endtask

  task automatic test_read_wrap;
    int brd = 0, rv = 0, dn = 0, er = 0;
    logic fin = 1'b0;
    ADDRBUFEN_N = 1'b0; WAIT_N = 1'b0; BD_IN = 8'h5A;
    start_burst(16'hFFFF, 8'd0, 1'b0);
    for (int k = 0; k < 40 && !fin; k++) begin
      if (!BRD_N) begin
        brd++;
        checks++; if (BA !== 16'hFFFF) begin failures++; $display("FAIL rd_strb_addr got=%h exp=ffff", BA); end
        WAIT_N = (brd >= 4);
        BD_IN  = (brd >= 4) ? 8'hA5 : 8'h5A;
      end
      if (RD_VALID) begin
        rv++;
        checks++; if (RD_DATA !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", RD_DATA); end
      end
      if (DONE) dn++;
      if (ERROR) er++;
      if (!BUSY) fin = 1'b1;
      else tick();
    end
    checks++; if (brd != 4) begin failures++; $display("FAIL rd_brd_low got=%0d exp=4", brd); end
    checks++; if (rv != 1) begin failures++; $display("FAIL rd_valid_count got=%0d exp=1", rv); end
    checks++; if ({fin, dn, er} != {1'b1, 32'd1, 32'd0}) begin
      failures++; $display("FAIL rd_end got=%b/%0d/%0d exp=1/1/0", fin, dn, er); end
    checks++; if (BA !== 16'h0000) begin failures++; $display("FAIL rd_addr_wrap got=%h exp=0000", BA); end
    ADDRBUFEN_N = 1'b1; WAIT_N = 1'b1;
  endtask

  task automatic test_timeout;
    int reqc = 0;
    logic seen = 1'b0;
    ADDRBUFEN_N = 1'b1;
    start_burst(16'h0100, 8'd0, 1'b1);
    for (int k = 0; k < 400 && !seen; k++) begin
      if (!DMA_N) reqc++;
      if (DONE) begin
        seen = 1'b1;
        checks++; if ({DMA_N, DONE, ERROR, OS3_N, BD_OE, BMREQ_N} !== 6'b111101) begin
          failures++; $display("FAIL to_err_cycle got=%b exp=111101", {DMA_N, DONE, ERROR, OS3_N, BD_OE, BMREQ_N}); end
      end else tick();
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL to_done_seen got=%b exp=1", seen); end
    checks++; if (reqc != 255) begin failures++; $display("FAIL to_req_cycles got=%0d exp=255", reqc); end
    tick();
    checks++; if ({BUSY, DONE, ERROR} !== 3'b000) begin
      failures++; $display("FAIL to_idle got=%b exp=000", {BUSY, DONE, ERROR}); end
  endtask

  task automatic test_abort;
    int np = 0;
    logic ab = 1'b0, fin = 1'b0;
    ADDRBUFEN_N = 1'b0; WR_VALID = 1'b1; WR_DATA = 8'h99;
    start_burst(16'h2000, 8'd5, 1'b1);
    for (int k = 0; k < 60 && !fin; k++) begin
      if (!BWR_N) np++;
      if (!BWR_N && np == 2 && !ab) begin
        IS3_N = 1'b0;
        tick();
        IS3_N = 1'b1;
        ab = 1'b1;
        checks++; if ({ERROR, DONE, BWR_N, BMREQ_N, DMA_N, OS3_N, BD_OE} !== 7'b1111110) begin
          failures++; $display("FAIL ab_err_cycle got=%b exp=1111110", {ERROR, DONE, BWR_N, BMREQ_N, DMA_N, OS3_N, BD_OE}); end
      end else if (!BUSY) fin = 1'b1;
      else tick();
    end
    checks++; if ({ab, fin} !== 2'b11) begin failures++; $display("FAIL ab_reached got=%b exp=11", {ab, fin}); end
    checks++; if (np != 2) begin failures++; $display("FAIL ab_pulses got=%0d exp=2", np); end
    ADDRBUFEN_N = 1'b1; WR_VALID = 1'b0;
  endtask

  task automatic test_wr_stall;
    ADDRBUFEN_N = 1'b0; WR_VALID = 1'b0; WR_DATA = 8'h77;
    start_burst(16'h3000, 8'd0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({WR_READY, BMREQ_N, BWR_N, BD_OUT} !== {3'b101, 8'h99}) begin
        failures++; $display("FAIL stall_addr%0d got=%h exp=%h", i, {WR_READY, BMREQ_N, BWR_N, BD_OUT}, {3'b101, 8'h99}); end
      if (i < 4) tick();
    end
    WR_VALID = 1'b1;
    tick();
    WR_VALID = 1'b0;
    checks++; if ({BWR_N, BMREQ_N, BD_OUT} !== {2'b00, 8'h77}) begin
      failures++; $display("FAIL stall_strb got=%h exp=%h", {BWR_N, BMREQ_N, BD_OUT}, {2'b00, 8'h77}); end
    tick(); tick();
    checks++; if ({DONE, OS3_N} !== 2'b10) begin failures++; $display("FAIL stall_rel got=%b exp=10", {DONE, OS3_N}); end
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL stall_idle got=%b exp=0", BUSY); end
    ADDRBUFEN_N = 1'b1;
  endtask

  task automatic test_reset_busy;
    logic hit = 1'b0;
    ADDRBUFEN_N = 1'b0; WAIT_N = 1'b0;
    start_burst(16'h1111, 8'd2, 1'b0);
    for (int k = 0; k < 10 && !hit; k++) begin
      if (!BRD_N) hit = 1'b1;
      else tick();
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rst_reach_strb got=%b exp=1", hit); end
    RST_N = 1'b0;
    tick();
    checks++; if ({DMA_N, OS3_N, BMREQ_N, BRD_N, BWR_N, BUSY, DONE, ERROR, BD_OE, RD_VALID} !== 10'b1111100000) begin
      failures++; $display("FAIL rst_mid_outs got=%b exp=1111100000", {DMA_N, OS3_N, BMREQ_N, BRD_N, BWR_N, BUSY, DONE, ERROR, BD_OE, RD_VALID}); end
    checks++; if (BA !== 16'h0) begin failures++; $display("FAIL rst_mid_ba got=%h exp=0000", BA); end
    RST_N = 1'b1; WAIT_N = 1'b1;
    tick();
    checks++; if ({BUSY, DONE, DMA_N} !== 3'b001) begin
      failures++; $display("FAIL rst_after got=%b exp=001", {BUSY, DONE, DMA_N}); end
    ADDRBUFEN_N = 1'b1; WR_VALID = 1'b1; WR_DATA = 8'h42;
    start_burst(16'h5000, 8'd0, 1'b1);
    START_ADDR = 16'h6000; LEN = 8'd7; DIR_WR = 1'b0; START = 1'b1;
    tick();
    START = 1'b0; ADDRBUFEN_N = 1'b0;
    tick();
    checks++; if ({WR_READY, BA} !== {1'b1, 16'h5000}) begin
      failures++; $display("FAIL busy_start_addr got=%h exp=%h", {WR_READY, BA}, {1'b1, 16'h5000}); end
    tick();
    checks++; if ({BWR_N, BRD_N, BD_OUT} !== {2'b01, 8'h42}) begin
      failures++; $display("FAIL busy_start_dir got=%h exp=%h", {BWR_N, BRD_N, BD_OUT}, {2'b01, 8'h42}); end
    tick(); tick();
    checks++; if ({OS3_N, DONE} !== 2'b01) begin failures++; $display("FAIL busy_start_rel got=%b exp=01", {OS3_N, DONE}); end
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL busy_start_len got=%b exp=0", BUSY); end
    ADDRBUFEN_N = 1'b1; WR_VALID = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; START_ADDR = '0; LEN = '0; DIR_WR = 1'b0;
    WR_DATA = '0; WR_VALID = 1'b0; ADDRBUFEN_N = 1'b1; IS3_N = 1'b1;
    WAIT_N = 1'b1; BD_IN = '0;
    test_reset();
    test_min_latency();
    test_write_burst();
    test_read_wrap();
    test_timeout();
    test_abort();
    test_wr_stall();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
